// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared definitions for the BCD calculator datapath: control
//               step codes, datapath FSM state type and the blank display code.
// Revision    : 1.0  initial release
// ============================================================================
package calc_pkg;

    // Step codes issued by the sequencing control unit.
    localparam logic [3:0] STEP_A1 = 4'd1;
    localparam logic [3:0] STEP_A2 = 4'd2;
    localparam logic [3:0] STEP_A3 = 4'd3;
    localparam logic [3:0] STEP_A4 = 4'd4;
    localparam logic [3:0] STEP_B1 = 4'd5;
    localparam logic [3:0] STEP_B2 = 4'd6;
    localparam logic [3:0] STEP_B3 = 4'd7;
    localparam logic [3:0] STEP_B4 = 4'd8;
    localparam logic [3:0] STEP_R1 = 4'd9;
    localparam logic [3:0] STEP_R2 = 4'd10;
    localparam logic [3:0] STEP_R3 = 4'd11;
    localparam logic [3:0] STEP_R4 = 4'd12;

    // Display code that the 7-segment driver renders as an unlit digit.
    localparam logic [3:0] DISP_BLANK = 4'hF;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_ADD  = 2'd1,
        S_SHOW = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adder.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adder
// Description : Combinational single-digit BCD adder with carry in/out.
//               a, b  : BCD digits
//               cin   : carry from the less significant digit
//               sum   : BCD sum digit
//               cout  : decimal carry to the next digit
// Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_raw;
    logic [3:0] w_adj;

    always_comb begin
        w_raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        // Adding 6 skips the six unused codes 10..15 so the low nibble wraps
        // back into the 0..9 range.
        w_adj = w_raw[3:0] + 4'd6;
        if (w_raw > 5'd9) begin
            sum  = w_adj;
            cout = 1'b1;
        end else begin
            sum  = w_raw[3:0];
            cout = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/operand_datapath.sv
`default_nettype none
// ============================================================================
// Module      : operand_datapath
// Description : Captures two BCD operands one digit per button pulse, adds
//               them digit-serially (LS digit first) and presents the sum one
//               digit per result step for the 7-segment driver.
//   clk          system clock
//   reset        asynchronous active-high reset
//   load_pulse   one-cycle debounced button strobe
//   step         control step code (A1..A4, B1..B4, R1..R4 = 1..12)
//   data_in      switch nibble, one BCD digit
//   disp_digit   registered display digit, DISP_BLANK = blank
//   busy         addition in progress
//   result_ready sum valid, sticky until reset
//   overflow     carry out of the most significant digit
//   bcd_err      sticky flag: a captured digit was above 9
// Revision    : 1.0  initial release
// ============================================================================
module operand_datapath
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int W      = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_pulse,
    input  logic [3:0]   step,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] disp_digit,
    output logic         busy,
    output logic         result_ready,
    output logic         overflow,
    output logic         bcd_err
);

    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(DIGITS - 1);

    // Index 0 is the least significant digit in every array.
    logic [W-1:0]       r_a [DIGITS];
    logic [W-1:0]       r_b [DIGITS];
    logic [W-1:0]       r_r [DIGITS];

    state_t             r_state;
    state_t             w_state_next;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_carry;
    logic               r_result_ready;
    logic               r_overflow;
    logic               r_bcd_err;
    logic [W-1:0]       r_disp;

    logic               w_capture;
    logic               w_start;
    logic [W-1:0]       w_sum;
    logic               w_cout;
    logic [W-1:0]       w_disp;

    // A digit is captured only while loading and only on an operand step.
    assign w_capture = (r_state == S_LOAD) && load_pulse &&
                       (step >= STEP_A1) && (step <= STEP_B4);
    assign w_start   = (r_state == S_LOAD) && load_pulse && (step == STEP_B4);

    // Single adder shared across all digit positions via r_idx.
    bcd_digit_adder u_adder (
        .a    (r_a[r_idx]),
        .b    (r_b[r_idx]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_LOAD;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD:  if (w_start) w_state_next = S_ADD;
            S_ADD:   if (r_idx == c_LAST) w_state_next = S_SHOW;
            S_SHOW:  w_state_next = S_SHOW;
            default: w_state_next = S_LOAD;
        endcase
    end

    // ---------------- Display selection ----------------
    always_comb begin
        w_disp = DISP_BLANK;
        if ((step >= STEP_A1) && (step <= STEP_B4)) begin
            w_disp = data_in;
        end else if (r_result_ready) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (step == 4'(STEP_R4 - i)) w_disp = r_r[i];
            end
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
                r_r[i] <= '0;
            end
            r_idx          <= '0;
            r_carry        <= 1'b0;
            r_result_ready <= 1'b0;
            r_overflow     <= 1'b0;
            r_bcd_err      <= 1'b0;
            r_disp         <= DISP_BLANK;
        end else begin
            r_disp <= w_disp;

            if (w_capture) begin
                if (data_in > W'(9)) r_bcd_err <= 1'b1;
                // A1/B1 is the most significant digit, so step maps downward.
                for (int i = 0; i < DIGITS; i++) begin
                    if (step == 4'(STEP_A4 - i)) r_a[i] <= data_in;
                    if (step == 4'(STEP_B4 - i)) r_b[i] <= data_in;
                end
            end

            if (w_start) begin
                r_idx   <= '0;
                r_carry <= 1'b0;
            end

            if (r_state == S_ADD) begin
                r_r[r_idx] <= w_sum;
                r_carry    <= w_cout;
                r_idx      <= r_idx + 1'b1;
                if (r_idx == c_LAST) begin
                    r_result_ready <= 1'b1;
                    if (r_bcd_err) begin
                        // Garbage operands: publish a clean zero result.
                        for (int i = 0; i < DIGITS; i++) r_r[i] <= '0;
                        r_overflow <= 1'b0;
                    end else begin
                        r_overflow <= w_cout;
                    end
                end
            end
        end
    end

    assign disp_digit   = r_disp;
    assign busy         = (r_state == S_ADD);
    assign result_ready = r_result_ready;
    assign overflow     = r_overflow;
    assign bcd_err      = r_bcd_err;

endmodule
`default_nettype wire

// File: tb/tb_operand_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_datapath
// Description : Scoreboard bench for operand_datapath. The stimulus process
//               advances a decimal-arithmetic reference model once per clock
//               and queues the expected outputs; a monitor process pops and
//               compares them one cycle later.
// Revision    : 1.0  initial release
// ============================================================================
module tb_operand_datapath;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_pulse = 1'b0;
    logic [3:0] step = 4'd0;
    logic [3:0] data_in = 4'd0;
    logic [3:0] disp_digit;
    logic       busy;
    logic       result_ready;
    logic       overflow;
    logic       bcd_err;

    operand_datapath #(.DIGITS(4), .W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_pulse   (load_pulse),
        .step         (step),
        .data_in      (data_in),
        .disp_digit   (disp_digit),
        .busy         (busy),
        .result_ready (result_ready),
        .overflow     (overflow),
        .bcd_err      (bcd_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] disp;
        logic       busy;
        logic       ready;
        logic       ov;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // ---------------- Reference model (decimal arithmetic) ----------------
    // Digit index 0 = least significant; phase 0 load, 1 add, 2 show.
    int ma[4], mb[4], mr[4];
    int m_phase, m_cnt, m_disp;
    bit m_err, m_ready, m_ov;

    task automatic model_edge(input bit lp, input int st, input int din, input bit rs);
        int nd;
        bit nerr;
        int va, vb, tot, p;
        if (rs) begin
            for (int i = 0; i < 4; i++) begin ma[i] = 0; mb[i] = 0; mr[i] = 0; end
            m_phase = 0; m_cnt = 0; m_err = 0; m_ready = 0; m_ov = 0; m_disp = 15;
            return;
        end
        nd = 15;
        if (st >= 1 && st <= 8) nd = din;
        else if (st >= 9 && st <= 12 && m_ready) nd = mr[12 - st];
        nerr = m_err || (m_phase == 0 && lp && st >= 1 && st <= 8 && din > 9);
        if (m_phase == 0) begin
            if (lp && st >= 1 && st <= 4) ma[4 - st] = din;
            if (lp && st >= 5 && st <= 8) mb[8 - st] = din;
            if (lp && st == 8) begin m_phase = 1; m_cnt = 0; end
        end else if (m_phase == 1) begin
            m_cnt++;
            if (m_cnt == 4) begin
                m_phase = 2;
                m_ready = 1;
                if (m_err) begin
                    for (int i = 0; i < 4; i++) mr[i] = 0;
                    m_ov = 0;
                end else begin
                    va = ma[3] * 1000 + ma[2] * 100 + ma[1] * 10 + ma[0];
                    vb = mb[3] * 1000 + mb[2] * 100 + mb[1] * 10 + mb[0];
                    tot = va + vb;
                    m_ov = (tot > 9999);
                    p = 1;
                    for (int i = 0; i < 4; i++) begin mr[i] = (tot / p) % 10; p = p * 10; end
                end
            end
        end
        m_err  = nerr;
        m_disp = nd;
    endtask

    // ---------------- Stimulus ----------------
    task automatic cyc(input bit lp, input int st, input int din, input bit rs);
        exp_t e;
        @(negedge clk);
        reset      = rs;
        load_pulse = lp;
        step       = 4'(st);
        data_in    = 4'(din);
        model_edge(lp, st, din, rs);
        e.disp  = 4'(m_disp);
        e.busy  = (m_phase == 1);
        e.ready = m_ready;
        e.ov    = m_ov;
        e.err   = m_err;
        q.push_back(e);
    endtask

    // Operands given as packed BCD, most significant nibble first.
    task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] ab;
        logic [3:0]  d;
        ab = {a, b};
        for (int k = 0; k < 8; k++) begin
            d = ab[31 - 4 * k -: 4];
            cyc(1'b1, k + 1, int'(d), 1'b0);
            if (k < 7) cyc(1'b0, k + 2, int'($urandom_range(0, 15)), 1'b0);
        end
    endtask

    task automatic show_all();
        repeat (5) cyc(1'b0, 9, 0, 1'b0);
        for (int s = 9; s <= 12; s++) cyc(1'b0, s, 0, 1'b0);
        for (int s = 9; s <= 12; s++) cyc(1'b1, s, 0, 1'b0);
        cyc(1'b1, 9, 0, 1'b0);
        cyc(1'b0, 13, 0, 1'b0);
        cyc(1'b0, 13, 0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 0, 0, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);
    endtask

    function automatic int rnd_digit();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(10, 15));
        return int'($urandom_range(0, 9));
    endfunction

    // ---------------- Monitor ----------------
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("disp_digit",   disp_digit,          e.disp);
                chk("busy",         {3'b000, busy},         {3'b000, e.busy});
                chk("result_ready", {3'b000, result_ready}, {3'b000, e.ready});
                chk("overflow",     {3'b000, overflow},     {3'b000, e.ov});
                chk("bcd_err",      {3'b000, bcd_err},      {3'b000, e.err});
            end
        end
    end

    // ---------------- Test sequence ----------------
    initial begin
        int npl;
        do_reset();

        // Basic sum 1234 + 5678 = 6912.
        load_ops(16'h1234, 16'h5678);
        show_all();

        // 9999 + 0001 overflows to 0000.
        do_reset();
        load_ops(16'h9999, 16'h0001);
        show_all();

        // Blank before result, then an invalid digit at step 2.
        do_reset();
        cyc(1'b0, 10, 0, 1'b0);
        cyc(1'b0, 13, 5, 1'b0);
        load_ops(16'h1A34, 16'h5678);
        show_all();

        // Pulses during every add cycle, then wrap pulses in show.
        do_reset();
        load_ops(16'h2222, 16'h3339);
        repeat (4) cyc(1'b1, 3, 7, 1'b0);
        cyc(1'b1, 8, 9, 1'b0);
        show_all();

        // Reset in the second add cycle, then a fresh load.
        do_reset();
        load_ops(16'h4321, 16'h1111);
        cyc(1'b0, 9, 0, 1'b0);
        cyc(1'b0, 9, 0, 1'b1);
        cyc(1'b0, 9, 0, 1'b0);
        load_ops(16'h0456, 16'h0789);
        show_all();

        // Randomised runs with re-pulses and random traffic after the add.
        for (int it = 0; it < 25; it++) begin
            do_reset();
            for (int k = 1; k <= 8; k++) begin
                npl = int'($urandom_range(1, 2));
                for (int p = 0; p < npl; p++) begin
                    cyc(1'b1, k, rnd_digit(), 1'b0);
                    if (k < 8) cyc(1'b0, k, int'($urandom_range(0, 15)), 1'b0);
                end
            end
            repeat (12) cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                            int'($urandom_range(0, 15)), 1'b0);
            for (int s = 9; s <= 12; s++) cyc(1'b0, s, 0, 1'b0);
            cyc(1'b0, 0, 0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, required 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
